// File: rtl/master_req_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : master_req_queue_if
// Purpose  : Master-side and crossbar-side bus bundle for master_req_queue.
// Revision : 1.0 - initial release
// ============================================================================
interface master_req_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m_req;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_cmd;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rvalid;

    logic              x_req;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata;
    logic              x_cmd;
    logic              x_ack;
    logic [DATA_W-1:0] x_rdata;

    // The queue sits in the slave position: it accepts from the master, replays to the crossbar.
    modport slave (
        input  m_req, m_addr, m_wdata, m_cmd,
        output m_ack, m_rdata, m_rvalid,
        output x_req, x_addr, x_wdata, x_cmd,
        input  x_ack, x_rdata
    );

    modport master (
        output m_req, m_addr, m_wdata, m_cmd,
        input  m_ack, m_rdata, m_rvalid,
        input  x_req, x_addr, x_wdata, x_cmd,
        output x_ack, x_rdata
    );
endinterface
`default_nettype wire

// File: rtl/master_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : master_req_queue
// Purpose  : In-order per-master request buffer replaying to a crossbar port.
//            Optional ack timeout enabled by macro REQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module master_req_queue #(
    parameter int DEPTH          = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    master_req_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]   c_PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] addr_mem_q  [DEPTH];
    logic [DATA_W-1:0] wdata_mem_q [DEPTH];
    logic              cmd_mem_q   [DEPTH];

    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q;
    logic [DATA_W-1:0] m_rdata_q;
    logic              m_rvalid_q;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_ack_pop;
    logic              w_to_pop;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W-1:0]  w_rd_idx;

    assign w_wr_idx = wr_ptr_q[PTR_W-1:0];
    assign w_rd_idx = rd_ptr_q[PTR_W-1:0];
    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Full blocks acceptance even when the head pops in the same cycle.
    assign w_push    = bus.m_req & ~w_full;
    assign w_ack_pop = ~w_empty & bus.x_ack;
    assign w_pop     = w_ack_pop | w_to_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            m_rdata_q  <= '0;
            m_rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= wr_ptr_d - rd_ptr_d;
            m_rvalid_q <= w_ack_pop & ~bus.x_cmd;
            if (w_ack_pop && !bus.x_cmd) begin
                m_rdata_q <= bus.x_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i]  <= '0;
                wdata_mem_q[i] <= '0;
                cmd_mem_q[i]   <= 1'b0;
            end
        end else if (w_push) begin
            addr_mem_q[w_wr_idx]  <= bus.m_addr;
            wdata_mem_q[w_wr_idx] <= bus.m_wdata;
            cmd_mem_q[w_wr_idx]   <= bus.m_cmd;
        end
    end

`ifdef REQ_TIMEOUT_EN
    localparam int                WAIT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_ONE  = WAIT_W'(1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q;

    // Fires on the stalled cycle that would bring the wait count to TIMEOUT_CYCLES; a real ack wins.
    assign w_to_pop = ~w_empty & ~bus.x_ack & (wait_q == c_WAIT_LAST);

    always_comb begin
        wait_d = wait_q + c_WAIT_ONE;
        if (w_empty || w_pop) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= w_to_pop;
        end
    end

    assign err_o = err_q;
`else
    logic w_unused_timeout;

    assign w_to_pop         = 1'b0;
    assign err_o            = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    assign bus.m_ack    = ~w_full;
    assign bus.m_rdata  = m_rdata_q;
    assign bus.m_rvalid = m_rvalid_q;
    assign bus.x_req    = ~w_empty;
    assign bus.x_addr   = w_empty ? '0 : addr_mem_q[w_rd_idx];
    assign bus.x_wdata  = w_empty ? '0 : wdata_mem_q[w_rd_idx];
    assign bus.x_cmd    = w_empty ? 1'b0 : cmd_mem_q[w_rd_idx];
    assign count_o      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_master_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_master_req_queue
// Purpose  : Directed vector bench for master_req_queue (DEPTH 4, timeout 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_master_req_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic        rst_n;
        logic        m_req;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic        m_cmd;
        logic        x_ack;
        logic [31:0] x_rdata;
        logic        e_mack;
        logic        e_xreq;
        logic [31:0] e_xaddr;
        logic [31:0] e_xwdata;
        logic        e_xcmd;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic [2:0]  e_count;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] count;
    logic       err;
    int         checks;
    int         errors;
    vec_t       vecs[$];

    master_req_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    master_req_queue #(
        .DEPTH          (DEPTH),
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .count_o (count),
        .err_o   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic req, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic cmd, input logic ack,
                         input logic [31:0] rdata);
        rst_n         = rst;
        bus.m_req     = req;
        bus.m_addr    = addr;
        bus.m_wdata   = wdata;
        bus.m_cmd     = cmd;
        bus.x_ack     = ack;
        bus.x_rdata   = rdata;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic mack, input logic xreq,
                               input logic [31:0] xaddr, input logic [31:0] xwdata,
                               input logic xcmd, input logic rvalid,
                               input logic [31:0] rdata, input logic [2:0] cnt);
        chk({tag, " m_ack"},    {31'b0, bus.m_ack},    {31'b0, mack});
        chk({tag, " x_req"},    {31'b0, bus.x_req},    {31'b0, xreq});
        chk({tag, " x_addr"},   bus.x_addr,            xaddr);
        chk({tag, " x_wdata"},  bus.x_wdata,           xwdata);
        chk({tag, " x_cmd"},    {31'b0, bus.x_cmd},    {31'b0, xcmd});
        chk({tag, " m_rvalid"}, {31'b0, bus.m_rvalid}, {31'b0, rvalid});
        chk({tag, " m_rdata"},  bus.m_rdata,           rdata);
        chk({tag, " count"},    {29'b0, count},        {29'b0, cnt});
        chk({tag, " err"},      {31'b0, err},          32'h0);
    endtask

    task automatic add(input logic rst, input logic req, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic cmd, input logic ack,
                       input logic [31:0] rdata, input logic mack, input logic xreq,
                       input logic [31:0] xaddr, input logic [31:0] xwdata,
                       input logic xcmd, input logic rvalid, input logic [31:0] erdata,
                       input logic [2:0] cnt);
        vec_t v;
        v = '{rst, req, addr, wdata, cmd, ack, rdata,
              mack, xreq, xaddr, xwdata, xcmd, rvalid, erdata, cnt};
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        //   rst req addr          wdata cmd ack rdata        | mack xreq xaddr         xwdata cmd rv rdata        cnt
        add(0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 0, 0, 32'h0,         0);
        add(1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 0, 0, 32'h0,         0);
        add(1, 1, 32'h8000_0010, 0, 0, 0, 32'h0,          1, 1, 32'h8000_0010, 0, 0, 0, 32'h0,         1);
        add(1, 0, 32'h0,         0, 0, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,         0, 0, 1, 32'hDEAD_BEEF, 0);
        add(1, 0, 32'h0,         0, 0, 0, 32'h0,          1, 0, 32'h0,         0, 0, 0, 32'hDEAD_BEEF, 0);
        // fill with writes 1..5 while the crossbar stalls
        add(1, 1, 32'h10,        1, 1, 0, 32'h0,          1, 1, 32'h10,        1, 1, 0, 32'hDEAD_BEEF, 1);
        add(1, 1, 32'h14,        2, 1, 0, 32'h0,          1, 1, 32'h10,        1, 1, 0, 32'hDEAD_BEEF, 2);
        add(1, 1, 32'h18,        3, 1, 0, 32'h0,          1, 1, 32'h10,        1, 1, 0, 32'hDEAD_BEEF, 3);
        add(1, 1, 32'h1C,        4, 1, 0, 32'h0,          0, 1, 32'h10,        1, 1, 0, 32'hDEAD_BEEF, 4);
        add(1, 1, 32'h20,        5, 1, 0, 32'h0,          0, 1, 32'h10,        1, 1, 0, 32'hDEAD_BEEF, 4);
        // full with pop: no bypass push, then the retry lands
        add(1, 1, 32'h20,        5, 1, 1, 32'h0,          1, 1, 32'h14,        2, 1, 0, 32'hDEAD_BEEF, 3);
        add(1, 1, 32'h20,        5, 1, 0, 32'h0,          0, 1, 32'h14,        2, 1, 0, 32'hDEAD_BEEF, 4);
        add(1, 0, 32'h0,         0, 0, 1, 32'h0,          1, 1, 32'h18,        3, 1, 0, 32'hDEAD_BEEF, 3);
        add(1, 0, 32'h0,         0, 0, 1, 32'h0,          1, 1, 32'h1C,        4, 1, 0, 32'hDEAD_BEEF, 2);
        add(1, 0, 32'h0,         0, 0, 1, 32'h0,          1, 1, 32'h20,        5, 1, 0, 32'hDEAD_BEEF, 1);
        // simultaneous push and pop while not full
        add(1, 1, 32'h24,        0, 0, 1, 32'h0,          1, 1, 32'h24,        0, 0, 0, 32'hDEAD_BEEF, 1);
        add(1, 0, 32'h0,         0, 0, 1, 32'h55,         1, 0, 32'h0,         0, 0, 1, 32'h55,        0);
        // ack while empty is ignored
        add(1, 0, 32'h0,         0, 0, 1, 32'h66,         1, 0, 32'h0,         0, 0, 0, 32'h55,        0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].m_req, vecs[i].m_addr, vecs[i].m_wdata,
                  vecs[i].m_cmd, vecs[i].x_ack, vecs[i].x_rdata);
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].e_mack, vecs[i].e_xreq,
                        vecs[i].e_xaddr, vecs[i].e_xwdata, vecs[i].e_xcmd,
                        vecs[i].e_rvalid, vecs[i].e_rdata, vecs[i].e_count);
        end

        // wrap-around: ten read push/pop pairs
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 32'h200 + i, 0, 0, 0, 0);
            tick();
            chk($sformatf("wrap%0d x_addr", i), bus.x_addr, 32'h200 + i);
            chk($sformatf("wrap%0d count1", i), {29'b0, count}, 32'd1);
            drive(1, 0, 0, 0, 0, 1, 32'h100 + i);
            tick();
            chk($sformatf("wrap%0d m_rvalid", i), {31'b0, bus.m_rvalid}, 32'd1);
            chk($sformatf("wrap%0d m_rdata", i), bus.m_rdata, 32'h100 + i);
            chk($sformatf("wrap%0d count0", i), {29'b0, count}, 32'd0);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("wrap idle m_rvalid", {31'b0, bus.m_rvalid}, 32'd0);

        // reset with three entries queued and a concurrent ack
        drive(1, 1, 32'h500, 32'h0, 0, 0, 0); tick();
        drive(1, 1, 32'h504, 32'hA1, 1, 0, 0); tick();
        drive(1, 1, 32'h508, 32'hA2, 1, 0, 0); tick();
        chk("pre-reset count", {29'b0, count}, 32'd3);
        drive(0, 0, 0, 0, 0, 1, 32'hAA);
        tick();
        check_state("midreset", 1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("post-reset m_rvalid", {31'b0, bus.m_rvalid}, 32'd0);
        drive(1, 1, 32'h300, 0, 0, 0, 0);
        tick();
        check_state("post-reset push", 1, 1, 32'h300, 32'h0, 0, 0, 32'h0, 1);
        drive(1, 0, 0, 0, 0, 1, 32'h77);
        tick();
        check_state("post-reset pop", 1, 0, 32'h0, 32'h0, 0, 1, 32'h77, 0);

        // stalled read: timeout drop, or indefinite wait when the feature is absent
        drive(1, 1, 32'h400, 0, 0, 0, 0);
        tick();
        chk("stall x_req rise", {31'b0, bus.x_req}, 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0);
`ifdef REQ_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) begin
                chk($sformatf("timeout wait%0d err", k), {31'b0, err}, 32'd0);
                chk($sformatf("timeout wait%0d x_req", k), {31'b0, bus.x_req}, 32'd1);
            end else begin
                chk("timeout err pulse", {31'b0, err}, 32'd1);
                chk("timeout count", {29'b0, count}, 32'd0);
                chk("timeout x_req", {31'b0, bus.x_req}, 32'd0);
                chk("timeout m_rvalid", {31'b0, bus.m_rvalid}, 32'd0);
            end
        end
        tick();
        chk("timeout err drop", {31'b0, err}, 32'd0);
        chk("timeout no late rvalid", {31'b0, bus.m_rvalid}, 32'd0);
`else
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("nowait%0d x_req", k), {31'b0, bus.x_req}, 32'd1);
            chk($sformatf("nowait%0d err", k), {31'b0, err}, 32'd0);
        end
        drive(1, 0, 0, 0, 0, 1, 32'h88);
        tick();
        chk("late ack m_rvalid", {31'b0, bus.m_rvalid}, 32'd1);
        chk("late ack m_rdata", bus.m_rdata, 32'h88);
        chk("late ack count", {29'b0, count}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/master_req_queue.md
Name: master_req_queue

Overview:
- Per-master request buffer between one bus master and its crossbar master port, one instance per master.
- Accepts posted req/addr/wdata/cmd transactions from the master and queues them in order.
- Replays each queued transaction to the crossbar, holding it stable until the crossbar returns ack.
- Returns read data to the master with a one-cycle valid strobe; decouples master issue rate from crossbar arbitration stalls.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- ADDR_W, 32, address width.
- DATA_W, 32, write/read data width.
- TIMEOUT_CYCLES, 255, ack wait limit; used only with REQ_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  reset, synchronous and active-low.
- m_req  in  1  master request.
- m_addr  in  ADDR_W  master address.
- m_wdata  in  DATA_W  master write data.
- m_cmd  in  1  1 = write, 0 = read.
- m_ack  out  1  accept; a push occurs when m_req & m_ack at posedge.
- m_rdata  out  DATA_W  read data returned to master.
- m_rvalid  out  1  one-cycle strobe, m_rdata valid.
- x_req  out  1  request to crossbar; high whenever queue is non-empty.
- x_addr  out  ADDR_W  head entry address.
- x_wdata  out  DATA_W  head entry write data.
- x_cmd  out  1  head entry command.
- x_ack  in  1  crossbar ack; a pop occurs when x_req & x_ack at posedge.
- x_rdata  in  DATA_W  crossbar read data, valid with x_ack.
- count  out  clog2(DEPTH)+1  occupancy.
- err  out  1  timeout drop strobe; tied 0 without REQ_TIMEOUT_EN.

Behaviour:
- Storage: circular array of DEPTH entries {addr, wdata, cmd}; rd_ptr and wr_ptr each carry one extra wrap bit.
  - full = pointers differ only in the MSB; empty = pointers equal.
  - Pointers wrap modulo 2*DEPTH.
- m_ack = ~full, combinational; it does not depend on m_req.
- Push: at posedge with m_req & ~full, write the entry and increment wr_ptr.
- Pop: at posedge with x_req & x_ack, increment rd_ptr.
  - If x_cmd = 0 (read), register m_rdata <= x_rdata and drive m_rvalid = 1 for exactly the next cycle.
  - If x_cmd = 1 (write), there is no m_rvalid.
- Head outputs: x_req = ~empty. x_addr, x_wdata and x_cmd come from the rd_ptr entry and stay stable until the pop. x_addr is 0 when empty.
- No fall-through: an entry pushed at edge N drives x_req from edge N onward, so the earliest pop is at edge N+1. Minimum latency from master accept to crossbar ack is 1 cycle.
- Simultaneous push and pop:
  - Allowed when not full; count is unchanged.
  - When full, m_ack = 0 even if a pop occurs that cycle (no bypass). The push is retried next cycle.
- x_ack while empty: ignored; no pointer, data or strobe change.
- count = wr_ptr - rd_ptr, registered.
- Reset (rst_n = 0 at posedge):
  - Pointers 0, count 0, x_req 0, m_rvalid 0, m_rdata 0, err 0. Entry contents are cleared to 0.
  - Any in-flight transaction is abandoned; an x_ack in the reset cycle is ignored.
- Ordering: strict FIFO; read responses return in issue order.

Optional Feature:
- Macro: REQ_TIMEOUT_EN.
- With the macro:
  - A wait counter clears on every pop, on reset and while the queue is empty. It increments each cycle x_req = 1 & x_ack = 0.
  - When it reaches TIMEOUT_CYCLES, the head entry is popped without ack and err pulses 1 for one cycle. No m_rvalid is generated, even for a read, and the counter clears.
  - If x_ack arrives in that same cycle, the normal pop wins and err stays 0.
- Without the macro: no counter, err constant 0, and the queue waits indefinitely.

Test Plan:
- Single read: push addr 0x8000_0010 cmd 0; x_ack = 1 one cycle after x_req rises with x_rdata 0xDEAD_BEEF -> m_rvalid pulses 1 cycle later, m_rdata = 0xDEAD_BEEF, count 1 -> 0.
- Fill: hold x_ack = 0, push 5 writes with wdata 1..5 -> first 4 accepted, m_ack = 0 on the 5th, count = 4. Release x_ack -> x_wdata is presented in order 1, 2, 3, 4, then the 5th push is accepted.
- Full plus simultaneous pop: queue full, m_req = 1, x_ack = 1 -> pop occurs, no push that cycle, count = 3. Next cycle the push is accepted, count = 4.
- Wrap-around: 10 push/pop pairs of reads with x_rdata = 0x100 + i -> m_rdata sequence 0x100..0x109, no loss, count returns to 0.
- Reset mid-operation: 3 entries queued, rst_n = 0 for 1 cycle while x_ack = 1 -> count 0, x_req 0, no m_rvalid. Next push behaves normally.
- REQ_TIMEOUT_EN, TIMEOUT_CYCLES = 8: one read queued, x_ack held 0 -> err pulses 8 cycles after x_req rises, no m_rvalid, count 0. Without the macro -> x_req stays 1 and err stays 0.
